evm_session_ctrl: RTL

Session controller for the three-candidate voting machine.
- Sequences each ballot: authority arm, single vote capture, per-candidate tally, post-vote lockout.
- Owns the poll lifecycle from open to closed.
- Sits between the raw authority/candidate/close buttons and the result display logic; it is the only block that writes the tallies.

---
 rtl/evm_session_if.sv | 38 +++
 rtl/evm_session_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/evm_session_if.sv
`default_nettype none
// ============================================================================
// evm_session_if -- button inputs and session/tally outputs of evm_session_ctrl
// Revision: 1.0
// ============================================================================
interface evm_session_if #(
    parameter int CNT_W = 16
);
    logic             auth;
    logic             vote1;
    logic             vote2;
    logic             vote3;
    logic             close_req;
    logic             armed;
    logic             vote_ack;
    logic [1:0]       vote_id;
    logic             err_multi;
    logic             timeout;
    logic             closed;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;
    logic [CNT_W-1:0] count3;
    logic [CNT_W-1:0] total;
    logic             sat;

    modport master (
        output auth, vote1, vote2, vote3, close_req,
        input  armed, vote_ack, vote_id, err_multi, timeout, closed,
               count1, count2, count3, total, sat
    );

    modport slave (
        input  auth, vote1, vote2, vote3, close_req,
        output armed, vote_ack, vote_id, err_multi, timeout, closed,
               count1, count2, count3, total, sat
    );
endinterface
`default_nettype wire

// File: rtl/evm_session_ctrl.sv
`default_nettype none
// ============================================================================
// evm_session_ctrl -- ballot sequencing, tallies and poll lifecycle for a
// three-candidate voting machine. Define ARM_TIMEOUT_EN to expire armed ballots.
// Revision: 1.0
// ============================================================================
module evm_session_ctrl #(
    parameter int CNT_W       = 16,
    parameter int HOLD_CYC    = 50,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic         clk,
    input  logic         reset,
    evm_session_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_CAST   = 3'd2,
        S_HOLD   = 3'd3,
        S_CLOSED = 3'd4
    } state_t;

    localparam int               HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("evm_session_ctrl: HOLD_CYC and TIMEOUT_CYC must be >= 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        w_btn;
    logic [4:0]        r_sync1;
    logic [4:0]        r_sync2;
    logic [4:0]        r_sync3;
    logic [4:0]        w_pulse;
    logic [2:0]        w_votes;
    logic              w_auth;
    logic              w_close;
    logic              w_single;
    logic              w_multi;
    logic [1:0]        w_sel;
    logic              w_cast;
    logic              w_err_multi;
    logic              w_pend_set;
    logic [1:0]        r_sel;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_close_pending;
    logic              r_vote_ack;
    logic [1:0]        r_vote_id;
    logic              r_err_multi;
    logic [CNT_W-1:0]  r_tally1;
    logic [CNT_W-1:0]  r_tally2;
    logic [CNT_W-1:0]  r_tally3;
    logic [CNT_W-1:0]  r_total;
    logic              r_sat;

    // Bit order: {close, vote3, vote2, vote1, auth}
    assign w_btn    = {bus.close_req, bus.vote3, bus.vote2, bus.vote1, bus.auth};
    assign w_pulse  = r_sync2 & ~r_sync3;
    assign w_auth   = w_pulse[0];
    assign w_votes  = w_pulse[3:1];
    assign w_close  = w_pulse[4];
    assign w_single = (w_votes == 3'b001) || (w_votes == 3'b010) || (w_votes == 3'b100);
    assign w_multi  = (w_votes[0] & w_votes[1]) | (w_votes[0] & w_votes[2]) |
                      (w_votes[1] & w_votes[2]);
    assign w_sel    = w_votes[0] ? 2'd1 : (w_votes[1] ? 2'd2 : 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

`ifdef ARM_TIMEOUT_EN
    localparam int              ARM_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(TIMEOUT_CYC - 1);

    logic [ARM_W-1:0] r_arm_cnt;
    logic             r_timeout;
    logic             w_timeout;
    logic             w_expire;

    assign w_expire = (r_arm_cnt == ARM_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (r_state == S_ARMED) r_arm_cnt <= r_arm_cnt + 1'b1;
            else                    r_arm_cnt <= '0;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cast       = 1'b0;
        w_err_multi  = 1'b0;
        w_pend_set   = 1'b0;
`ifdef ARM_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_close)     w_state_next = S_CLOSED;
                else if (w_auth) w_state_next = S_ARMED;
            end
            S_ARMED: begin
                w_err_multi = w_multi;
                // A single vote beats a simultaneous close; the close is deferred
                if (w_single) begin
                    w_state_next = S_CAST;
                    w_pend_set   = w_close;
                end else if (w_close) begin
                    w_state_next = S_CLOSED;
                end
`ifdef ARM_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_next = S_IDLE;
                    w_timeout    = 1'b1;
                end
`endif
            end
            S_CAST: begin
                w_cast       = 1'b1;
                w_pend_set   = w_close;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                w_pend_set = w_close;
                if (r_hold_cnt == HOLD_LAST)
                    w_state_next = (r_close_pending || w_close) ? S_CLOSED : S_IDLE;
            end
            S_CLOSED: begin
                w_state_next = S_CLOSED;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel           <= 2'd0;
            r_hold_cnt      <= '0;
            r_close_pending <= 1'b0;
            r_vote_ack      <= 1'b0;
            r_vote_id       <= 2'd0;
            r_err_multi     <= 1'b0;
            r_tally1        <= '0;
            r_tally2        <= '0;
            r_tally3        <= '0;
            r_total         <= '0;
            r_sat           <= 1'b0;
        end else begin
            r_vote_ack  <= w_cast;
            r_err_multi <= w_err_multi;
            if (w_pend_set) r_close_pending <= 1'b1;
            if (r_state == S_ARMED && w_single) r_sel <= w_sel;
            if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
            else                   r_hold_cnt <= '0;
            if (w_cast) begin
                r_vote_id <= r_sel;
                case (r_sel)
                    2'd1: if (r_tally1 == CNT_MAX) r_sat <= 1'b1; else r_tally1 <= r_tally1 + 1'b1;
                    2'd2: if (r_tally2 == CNT_MAX) r_sat <= 1'b1; else r_tally2 <= r_tally2 + 1'b1;
                    2'd3: if (r_tally3 == CNT_MAX) r_sat <= 1'b1; else r_tally3 <= r_tally3 + 1'b1;
                    default: ;
                endcase
                if (r_total == CNT_MAX) r_sat   <= 1'b1;
                else                    r_total <= r_total + 1'b1;
            end
        end
    end

    // Per-candidate tallies stay hidden until the poll is closed
    assign bus.armed     = (r_state == S_ARMED);
    assign bus.closed    = (r_state == S_CLOSED);
    assign bus.vote_ack  = r_vote_ack;
    assign bus.vote_id   = r_vote_id;
    assign bus.err_multi = r_err_multi;
    assign bus.count1    = bus.closed ? r_tally1 : '0;
    assign bus.count2    = bus.closed ? r_tally2 : '0;
    assign bus.count3    = bus.closed ? r_tally3 : '0;
    assign bus.total     = r_total;
    assign bus.sat       = r_sat;

endmodule
`default_nettype wire
